weighted_trend_window: RTL

//  Parametrised successor to the single-bit weighted-majority detector.
//  - Keeps a sliding window of the last WIN serial samples.
//  - Scores the window as uniform or recency-weighted (linear) and decides the trend with a runtime hysteresis band.
//  - Flags when the window is first full and pulses on every trend flip.
//  - Sits between the pin-level input sampler and the tt_um top, driving uo_out.

---
 rtl/weighted_trend_window.sv | 108 ++++++++++
 1 files changed

// File: rtl/weighted_trend_window.sv
// weighted_trend_window
// Sliding window of the last WIN serial samples, scored either uniformly or
// with linear recency weights. A runtime hysteresis band sets the trend
// decision. The block flags when the window first fills and pulses whenever
// the trend flips.
module weighted_trend_window #(
  parameter int WIN = 8,  // window depth, 2..32
  parameter int SW  = 8   // score width, 2^SW > WIN*(WIN+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          mode,
  input  logic [SW-1:0] hyst,
  output logic          trend,
  output logic          primed,
  output logic          change,
  output logic [SW-1:0] score
);

  // Fill counter width: it has to hold the value WIN itself.
  localparam int FW = $clog2(WIN + 1);
  // Comparison width: 2*S and T+hyst both have to fit without wrapping.
  localparam int CW = SW + 2;

  localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
  localparam logic [CW-1:0] T_UNI     = CW'(WIN);
  localparam logic [CW-1:0] T_LIN     = CW'(WIN * (WIN + 1) / 2);

  logic [WIN-1:0] window_q, window_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           trend_q, trend_d;
  logic           primed_q;
  logic           change_q;
  logic [SW-1:0]  score_q;

  logic [CW-1:0]  score_d;
  logic [CW-1:0]  total;
  logic [CW-1:0]  hyst_w;
  logic           full_d;
  logic           rise;
  logic           fall;

  // Next window, score and trend decision, all derived from the window
  // value that includes the sample arriving on this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so
    // no path can leave it unassigned and infer a latch.
    window_d = {window_q[WIN-2:0], in_bit};
    fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    full_d   = (fill_d == FILL_FULL);
    total    = mode ? T_LIN : T_UNI;
    hyst_w   = CW'(hyst);
    score_d  = '0;
    for (int i = 0; i < WIN; i++) begin
      if (window_d[i]) begin
        score_d = score_d + (mode ? CW'(WIN - i) : CW'(1));
      end
    end
    rise = (score_d << 1) > (total + hyst_w);
    // A band at least as wide as T leaves no room below it; the guard keeps
    // the subtraction from wrapping into a huge threshold.
    fall = (hyst_w < total) && ((score_d << 1) < (total - hyst_w));
    trend_d = trend_q;
    if (full_d) begin
      if (rise) begin
        trend_d = 1'b1;
      end else if (fall) begin
        trend_d = 1'b0;
      end
    end
  end

  // State update: flush on rst/clear, capture and evaluate on a valid
  // sample, otherwise hold everything and drop the change pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst || clear) begin
      // NOTE: the window is a plain shift register rather than a memory, and
      // its contents feed the score directly, so it is flushed along with
      // the control state.
      window_q <= '0;
      fill_q   <= '0;
      trend_q  <= 1'b0;
      primed_q <= 1'b0;
      change_q <= 1'b0;
      score_q  <= '0;
    end else if (in_valid) begin
      window_q <= window_d;
      fill_q   <= fill_d;
      score_q  <= score_d[SW-1:0];
      primed_q <= full_d;
      trend_q  <= trend_d;
      change_q <= (trend_d != trend_q);
    end else begin
      change_q <= 1'b0;
    end
  end

  assign trend  = trend_q;
  assign primed = primed_q;
  assign change = change_q;
  assign score  = score_q;

endmodule
